// File: rtl/tt_capture_pkg.sv
// Shared types and helpers for the truth-table capture block.
package tt_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Row 0 (all inputs low) lands in the MSB of the table.
  function automatic int row_bit(input int r, input int tt_w);
    return tt_w - 1 - r;
  endfunction

  function automatic int cnt_width(input int settle_cycles);
    int w;
    w = $clog2(settle_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tt_row_sequencer.sv
// Walks the input rows, holding each one for SETTLE_CYCLES+1 cycles.
module tt_row_sequencer
  import tt_capture_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            run,
  output logic [N_IN-1:0] row,
  output logic            sample_strobe,
  output logic            last_row
);

  localparam int              CNT_W    = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0]  ROW_LAST = '1;

  logic [CNT_W-1:0] cnt;

  assign sample_strobe = run && (cnt == CNT_LAST);
  assign last_row      = (row == ROW_LAST);

  // The row counter parks on the last row; the FSM leaves RUN on that strobe.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      row <= '0;
    end else if (sample_strobe) begin
      cnt <= '0;
      if (!last_row) row <= row + 1'b1;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tt_capture.sv
// Sweeps every input row of a combinational netlist and assembles its truth table.
module tt_capture
  import tt_capture_pkg::*;
#(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [(2**N_IN)-1:0] exp_tt,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 tt_valid,
  input  logic                 tt_ready,
  output logic [(2**N_IN)-1:0] tt_data,
  output logic                 mismatch,
  output logic [N_IN-1:0]      mismatch_row,
  output logic                 busy
);

  localparam int TT_W = 2**N_IN;

  state_t            state, state_nxt;
  logic [N_IN-1:0]   row, bit_idx;
  logic              sample_strobe, last_row, start_fire, accept, finish;
  logic [TT_W-1:0]   exp_q, acc_tt, tt_nxt;
  logic              acc_mis, mis_nxt, sample_err;
  logic [N_IN-1:0]   acc_row, row_nxt;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign tt_valid    = (state == DONE);
  assign start_fire  = start_valid && start_ready;
  assign accept      = tt_valid && tt_ready;
  assign finish      = sample_strobe && last_row;
  assign dut_in      = (state == RUN) ? row : '0;
  assign bit_idx     = N_IN'(row_bit(int'(row), TT_W));

  tt_row_sequencer #(
    .N_IN          (N_IN),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .clear         (start_fire),
    .run           (state == RUN),
    .row           (row),
    .sample_strobe (sample_strobe),
    .last_row      (last_row)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_fire) state_nxt = RUN;
      RUN:     if (finish)     state_nxt = DONE;
      DONE:    if (accept)     state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Only the first differing row is remembered, so it is the lowest index.
  always_comb begin
    tt_nxt          = acc_tt;
    tt_nxt[bit_idx] = dut_out;
    sample_err      = (dut_out != exp_q[bit_idx]);
    mis_nxt         = acc_mis;
    row_nxt         = acc_row;
    if (sample_err && !acc_mis) begin
      mis_nxt = 1'b1;
      row_nxt = row;
    end
  end

  always_ff @(posedge clk) begin
    if (start_fire) exp_q <= exp_tt;
  end

  always_ff @(posedge clk) begin
    if (start_fire) begin
      acc_tt  <= '0;
      acc_mis <= 1'b0;
      acc_row <= '0;
    end else if (sample_strobe) begin
      acc_tt  <= tt_nxt;
      acc_mis <= mis_nxt;
      acc_row <= row_nxt;
    end
  end

  // Results are published only on completion, so an aborted sweep never shows.
  always_ff @(posedge clk) begin
    if (rst) begin
      tt_data      <= '0;
      mismatch     <= 1'b0;
      mismatch_row <= '0;
    end else if (finish) begin
      tt_data      <= tt_nxt;
      mismatch     <= mis_nxt;
      mismatch_row <= row_nxt;
    end
  end

endmodule

// File: tb/tb_tt_capture.sv
// Randomized bench for tt_capture against a table-level reference model.
module tb_tt_capture;

  localparam int N_IN = 4;
  localparam int TT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic            start_valid, start_ready, dut_out, tt_valid, tt_ready, mismatch, busy;
  logic [TT_W-1:0] exp_tt, tt_data, tbl;
  logic [N_IN-1:0] dut_in, mismatch_row;

  logic            start_valid_z, start_ready_z, dut_out_z, tt_valid_z, tt_ready_z, mismatch_z, busy_z;
  logic [TT_W-1:0] exp_tt_z, tt_data_z, tbl_z;
  logic [N_IN-1:0] dut_in_z, mismatch_row_z;

  // Netlist stand-in: dut_in[3] is input _0, so row r reads table bit 15-r.
  assign dut_out   = tbl[~dut_in];
  assign dut_out_z = tbl_z[~dut_in_z];

  tt_capture #(.N_IN(N_IN), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .exp_tt(exp_tt), .dut_in(dut_in), .dut_out(dut_out), .tt_valid(tt_valid),
    .tt_ready(tt_ready), .tt_data(tt_data), .mismatch(mismatch),
    .mismatch_row(mismatch_row), .busy(busy)
  );

  tt_capture #(.N_IN(N_IN), .SETTLE_CYCLES(0)) u_dut_z (
    .clk(clk), .rst(rst), .start_valid(start_valid_z), .start_ready(start_ready_z),
    .exp_tt(exp_tt_z), .dut_in(dut_in_z), .dut_out(dut_out_z), .tt_valid(tt_valid_z),
    .tt_ready(tt_ready_z), .tt_data(tt_data_z), .mismatch(mismatch_z),
    .mismatch_row(mismatch_row_z), .busy(busy_z)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
  endtask

  function automatic logic [3:0] model_row(input logic [15:0] t, input logic [15:0] e);
    logic [15:0] d;
    d = t ^ e;
    for (int r = 0; r < TT_W; r++) begin
      if (d[15]) return 4'(r);
      d = d << 1;
    end
    return 4'd0;
  endfunction

  task automatic sweep_a(input logic [15:0] t, input logic [15:0] e, input int hold, input string tag);
    int lat, seq_err, stab_err;
    logic mis_m;
    logic [3:0] row_m;
    mis_m = ((t ^ e) != 16'h0);
    row_m = model_row(t, e);
    tbl = t; exp_tt = e; start_valid = 1'b1;
    chk({tag, ".start_ready"}, start_ready, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    exp_tt = 16'($urandom);
    lat = 0; seq_err = 0;
    while (!tt_valid && lat < 200) begin
      if (dut_in !== 4'(lat / 3)) seq_err++;
      if (!busy || start_ready) seq_err++;
      start_valid = 1'($urandom_range(0, 1));
      tt_ready    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    tt_ready = 1'b0;
    chk({tag, ".latency"}, lat, 48);
    chk({tag, ".row_seq"}, seq_err, 0);
    chk({tag, ".tt_data"}, tt_data, t);
    chk({tag, ".mismatch"}, mismatch, mis_m);
    chk({tag, ".mismatch_row"}, mismatch_row, row_m);
    stab_err = 0;
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (!tt_valid || tt_data !== t || mismatch !== mis_m || mismatch_row !== row_m
          || start_ready || dut_in !== 4'd0) stab_err++;
    end
    chk({tag, ".hold_stable"}, stab_err, 0);
    start_valid = 1'b0; tt_ready = 1'b1;
    @(posedge clk); #1;
    tt_ready = 1'b0;
    chk({tag, ".accepted"}, {tt_valid, busy, start_ready}, 3'b001);
    chk({tag, ".kept"}, tt_data, t);
  endtask

  task automatic sweep_z(input logic [15:0] t, input logic [15:0] e, input string tag);
    int lat, seq_err;
    tbl_z = t; exp_tt_z = e; start_valid_z = 1'b1;
    @(posedge clk); #1;
    start_valid_z = 1'b0;
    lat = 0; seq_err = 0;
    while (!tt_valid_z && lat < 100) begin
      if (dut_in_z !== 4'(lat)) seq_err++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, 16);
    chk({tag, ".row_seq"}, seq_err, 0);
    chk({tag, ".tt_data"}, tt_data_z, t);
    chk({tag, ".mismatch"}, mismatch_z, ((t ^ e) != 16'h0));
    chk({tag, ".mismatch_row"}, mismatch_row_z, model_row(t, e));
    tt_ready_z = 1'b1;
    @(posedge clk); #1;
    tt_ready_z = 1'b0;
    chk({tag, ".accepted"}, tt_valid_z, 0);
  endtask

  initial begin
    int c, v1, r1, v2;
    logic [15:0] d1, d2, t, m;

    rst = 1'b1;
    start_valid = 1'b0; tt_ready = 1'b0; exp_tt = '0; tbl = 16'h240F;
    start_valid_z = 1'b0; tt_ready_z = 1'b0; exp_tt_z = '0; tbl_z = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.ctrl", {start_ready, tt_valid, busy}, 3'b100);
    chk("reset.data", {tt_data, mismatch, mismatch_row, dut_in}, 25'h0);

    sweep_a(16'h240F, 16'h240F, 0, "match");
    sweep_a(16'h240F, 16'h240E, 0, "miss_lsb");
    sweep_a(16'h240F, 16'hA40F, 0, "miss_msb");
    sweep_a(16'h240F, 16'h240F, 10, "backpressure");

    for (int k = 0; k < 4; k++) begin
      t = 16'($urandom);
      m = (k == 0) ? 16'h0 : ((k == 3) ? 16'($urandom) : (16'h1 << $urandom_range(0, 15)));
      sweep_a(t, t ^ m, int'($urandom_range(0, 5)), "random");
    end

    sweep_z(16'hFFFF, 16'hFFFF, "settle0_ones");
    t = 16'($urandom);
    sweep_z(t, t ^ 16'h0100, "settle0_rand");

    // Abort on the sampling edge of row 7 (edge 24 after the handshake).
    tbl = 16'h240F; exp_tt = 16'h0000; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    chk("abort.row7_applied", dut_in, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.ctrl", {start_ready, tt_valid, busy}, 3'b100);
    chk("abort.data", {tt_data, mismatch, mismatch_row, dut_in}, 25'h0);
    sweep_a(16'h240F, 16'h240F, 2, "after_abort");

    tbl = 16'h240F; exp_tt = 16'h240F; start_valid = 1'b1; tt_ready = 1'b1;
    @(posedge clk); #1;
    c = 0; v1 = -1; r1 = -1; v2 = -1; d1 = '0; d2 = '0;
    while (c < 300 && v2 < 0) begin
      if (tt_valid && v1 < 0) begin
        v1 = c; d1 = tt_data;
      end else if (tt_valid && r1 >= 0) begin
        v2 = c; d2 = tt_data;
      end
      if (v1 >= 0 && r1 < 0 && start_ready) r1 = c;
      @(posedge clk); #1;
      c++;
    end
    start_valid = 1'b0; tt_ready = 1'b0;
    chk("b2b.first_valid", v1, 48);
    chk("b2b.ready_gap", r1 - v1, 1);
    chk("b2b.second_valid", v2, 98);
    chk("b2b.first_data", d1, 16'h240F);
    chk("b2b.second_data", d2, 16'h240F);
    chk("b2b.idle", {busy, tt_valid}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tt_capture.md
Name: tt_capture

Overview:
Hardware truth-table extractor, the read-back counterpart of the truth-table-to-NOR/NOT netlist flow. It sweeps every input row of a combinational gate netlist under test, samples its single output after a programmable settle time, and assembles the hex truth table in the same bit order the synthesis flow consumes. It optionally compares the result against an expected table so synthesized netlists can be checked in simulation or on FPGA.

Parameters:
N_IN, 4, number of DUT inputs (1..6)
SETTLE_CYCLES, 2, extra cycles each row is held before sampling (0 allowed)
TT_W, 2**N_IN, truth-table width; derived localparam, not overridable

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start_valid  in  1  request a sweep
start_ready  out  1  high only in IDLE
exp_tt  in  TT_W  expected table; latched on the start handshake
dut_in  out  N_IN  row applied to DUT; dut_in[N_IN-1] drives netlist input _0, dut_in[0] drives the last input
dut_out  in  1  DUT output, combinational from dut_in
tt_valid  out  1  result available
tt_ready  in  1  consumer accepts result
tt_data  out  TT_W  captured table
mismatch  out  1  tt_data != latched exp_tt; valid with tt_valid
mismatch_row  out  N_IN  lowest row index r whose sample differed; 0 if none
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; dut_in, tt_data, tt_valid, mismatch, mismatch_row, busy all 0; start_ready=1 the cycle after.
- Bit order: row r (0..TT_W-1) is stored in tt_data[TT_W-1-r]. Row 0 (all inputs 0) is the MSB of the hex string.
- FSM states: IDLE, RUN, DONE.
- IDLE: dut_in held 0. On start_valid && start_ready, at that edge: exp_tt latched, row<=0, cnt<=0, dut_in<=0, the tt/mismatch accumulators are cleared, state<=RUN.
- RUN: each edge with cnt<SETTLE_CYCLES sets cnt++. At the edge with cnt==SETTLE_CYCLES, the module:
  - samples dut_out into tt[TT_W-1-row];
  - if the sample != exp_tt[TT_W-1-row] and no mismatch is recorded yet, sets mismatch<=1 and mismatch_row<=row;
  - sets cnt<=0, row<=row+1, dut_in<=row+1.
- Each row is held exactly SETTLE_CYCLES+1 cycles.
- Last row: on the sampling edge of row TT_W-1, state<=DONE, tt_valid<=1, and dut_in<=0. The row counter does not wrap into another sweep.
- Latency: tt_valid goes high exactly TT_W*(SETTLE_CYCLES+1) edges after the start handshake edge. With the defaults this is 48.
- DONE: tt_data, mismatch and mismatch_row are stable while tt_valid=1. On tt_valid && tt_ready: tt_valid<=0, state<=IDLE.
- No same-cycle restart: start_ready rises the cycle after the result is accepted. tt_data keeps its last value in IDLE.
- start_valid while busy is ignored and not queued.
- tt_ready while tt_valid=0 is ignored.
- rst asserted mid-sweep or in DONE aborts the operation. No partial result is ever presented.
- dut_out is sampled in the RUN cycle immediately before the sampling edge. The DUT and dut_out are assumed glitch-settled by then; the module adds no synchronizer.

Decomposition:
- Package tt_capture_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function row_bit(r, TT_W) returning TT_W-1-r;
  - the settle-counter width function clog2(SETTLE_CYCLES+1), minimum 1.
- One sub-module, tt_row_sequencer, holds the row and settle counters and emits sample_strobe and last_row. The FSM, accumulators and handshakes stay in tt_capture.

Test Plan:
1. DUT = the 0x240F NOR/NOT gate netlist, exp_tt=0x240F, defaults -> tt_valid at edge 48 after the handshake; tt_data=0x240F, mismatch=0, mismatch_row=0.
2. Same DUT, exp_tt=0x240E -> tt_data=0x240F, mismatch=1, mismatch_row=15. With exp_tt=0xA40F instead -> mismatch_row=0.
3. DUT output tied to 1, SETTLE_CYCLES=0 -> tt_data=0xFFFF at edge 16. Each dut_in value 0..15 appears for exactly 1 cycle, in ascending order.
4. Backpressure: hold tt_ready=0 for 10 cycles after tt_valid -> tt_valid, tt_data and mismatch are stable. start_valid pulses during RUN and DONE produce no new sweep. After acceptance, start_ready=1 exactly one cycle later.
5. rst pulsed at the sampling edge of row 7 -> next cycle shows IDLE, all outputs 0, start_ready=1. A fresh sweep then yields the correct 0x240F.
6. Back-to-back: two sweeps with start_valid held high and tt_ready high -> the second handshake occurs 1 cycle after the first result is accepted, and both results equal 0x240F.
